// File: rtl/keccak_pkg.sv
// Shared SHA3-256 padding types, constants and helpers for keccak_padder and keccak_xor.
package keccak_pkg;

    localparam int WIDTH      = 64;
    localparam int RATE_LANES = 17;

    typedef enum logic {FILL, EMIT} state_t;

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef logic [0:4][0:4][WIDTH-1:0] state_arr_t;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_xy_t;

    localparam logic [4:0]       LAST_LANE  = 5'(RATE_LANES - 1);
    localparam logic [WIDTH-1:0] FINAL_LANE = {PAD_FINAL, 56'h0};

    function automatic lane_xy_t lane_xy(input logic [4:0] l);
        lane_xy_t r;
        r.x = 3'(l % 5'd5);
        r.y = 3'(l / 5'd5);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] byte_mask(input logic [3:0] n);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n)) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] pad_byte_at(input logic [3:0] n);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == int'(n)) p[i*8 +: 8] = PAD_DOMAIN;
        end
        return p;
    endfunction

endpackage

// File: rtl/keccak_padder.sv
// Packs a little-endian 64-bit word stream into padded SHA3-256 rate blocks for keccak_xor.
module keccak_padder
    import keccak_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      in_data,
    input  logic [3:0]       in_bytes,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output state_arr_t       block,
    output logic             block_valid,
    output logic             last_block,
    input  logic             xor_ready
);

    localparam lane_xy_t FIN = lane_xy(LAST_LANE);

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       need_extra_q, need_extra_d;
    state_arr_t block_q, block_d;
    logic       block_valid_q, block_valid_d;
    logic       last_block_q, last_block_d;

    logic [3:0]       nb;
    logic [63:0]      word;
    lane_xy_t         cur;
    lane_xy_t         nxt;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        need_extra_d = need_extra_q;
        block_d      = block_q;
        last_block_d = last_block_q;

        nb   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        word = in_last ? (in_data & byte_mask(nb)) : in_data;
        cur  = lane_xy(idx_q);
        nxt  = lane_xy(idx_q + 5'd1);

        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    block_d[cur.x][cur.y] = word;
                    if (!in_last) begin
                        if (idx_q == LAST_LANE) begin
                            last_block_d = 1'b0;
                            state_d      = EMIT;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end else if (nb != 4'd8) begin
                        // Domain byte lands right after the data; may share lane 16 with the final bit.
                        block_d[cur.x][cur.y] = word | pad_byte_at(nb);
                        block_d[FIN.x][FIN.y] = block_d[FIN.x][FIN.y] | FINAL_LANE;
                        last_block_d          = 1'b1;
                        state_d               = EMIT;
                    end else if (idx_q != LAST_LANE) begin
                        block_d[nxt.x][nxt.y] = block_d[nxt.x][nxt.y] | pad_byte_at(4'd0);
                        block_d[FIN.x][FIN.y] = block_d[FIN.x][FIN.y] | FINAL_LANE;
                        last_block_d          = 1'b1;
                        state_d               = EMIT;
                    end else begin
                        // Message filled the block exactly; padding needs a block of its own.
                        need_extra_d = 1'b1;
                        last_block_d = 1'b0;
                        state_d      = EMIT;
                    end
                end
            end
            EMIT: begin
                if (xor_ready) begin
                    block_d = '0;
                    if (need_extra_q) begin
                        block_d[0][0]         = pad_byte_at(4'd0);
                        block_d[FIN.x][FIN.y] = FINAL_LANE;
                        last_block_d          = 1'b1;
                        need_extra_d          = 1'b0;
                    end else begin
                        idx_d        = '0;
                        last_block_d = 1'b0;
                        state_d      = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        block_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            idx_q         <= '0;
            need_extra_q  <= 1'b0;
            block_q       <= '0;
            block_valid_q <= 1'b0;
            last_block_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            need_extra_q  <= need_extra_d;
            block_q       <= block_d;
            block_valid_q <= block_valid_d;
            last_block_q  <= last_block_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign block       = block_q;
    assign block_valid = block_valid_q;
    assign last_block  = last_block_q;

endmodule

// File: doc/keccak_padder.md
# keccak_padder

Upstream feeder for `keccak_xor`. Accepts a message as a stream of little-endian 64-bit words and applies SHA3-256 padding: the 0x06 domain byte and a final 0x80 bit. It assembles each 1088-bit rate block into the 5×5×64 lane array, with capacity lanes zeroed, and holds each block on `block`/`block_valid`/`last_block` until `keccak_xor` accepts it. Outputs connect directly to `keccak_xor` `Din`/`Din_valid`/`Last_block`.

## Interface
- `WIDTH`, 64, lane width in bits
- `RATE_LANES`, 17, lanes per rate block (1088 bits, SHA3-256)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset: synchronous, active-high
- `in_data`  in  64  message word; byte 0 in [7:0] is the earliest byte
- `in_bytes`  in  4  valid bytes in `in_data`, 0..8; honoured only with `in_last`
- `in_last`  in  1  word is the final word of the message
- `in_valid`  in  1  word present
- `in_ready`  out  1  padder accepts a word this cycle
- `block`  out  [0:4][0:4][WIDTH-1:0]  assembled block; lane L = `block[L%5][L/5]`
- `block_valid`  out  1  block held and stable
- `last_block`  out  1  held block is the final block of the message
- `xor_ready`  in  1  `keccak_xor` can take the block (its `Ready`)

## Operation
- **States.**
  - FILL: `in_ready`=1.
  - EMIT: `block_valid`=1, `in_ready`=0.
  - A `need_extra` flag tracks a pending pad-only block.
- **Word counter.** `idx` runs 0..16. Each accepted word (`in_valid && in_ready`) is written, masked, into lane `idx`.
- **Masking.** On a non-last word, all 8 bytes are valid. On a last word, bytes ≥ `in_bytes` are zeroed. `in_bytes`>8 is clamped to 8.
- **FILL, non-last word, `idx`<16:** `idx`++.
- **FILL, non-last word, `idx`==16:** go to EMIT with `last_block`=0.
- **FILL, last word with `in_bytes`<8:**
  - OR 0x06 into byte `in_bytes` of lane `idx`.
  - OR 0x80 into byte 7 of lane 16; the two may coincide, giving 0x86.
  - Set `last_block`=1 and go to EMIT.
- **FILL, last word with `in_bytes`==8, `idx`<16:**
  - OR 0x06 into byte 0 of lane `idx`+1.
  - OR 0x80 into byte 7 of lane 16.
  - Set `last_block`=1 and go to EMIT.
- **FILL, last word with `in_bytes`==8, `idx`==16:**
  - The block goes out with `last_block`=0.
  - Set `need_extra`=1 and go to EMIT.
- **EMIT, transfer** (`block_valid && xor_ready` at an edge):
  - If `need_extra`: load a pad-only block (lane0=0x06, lane16=0x8000000000000000, rest 0), set `last_block`=1, clear `need_extra`, stay in EMIT.
  - Otherwise: clear `block`, `idx`, and `last_block`, then go to FILL.
- **Capacity lanes** 17..24 are always 0.
- **Empty message:** `in_last` with `in_bytes`=0 at `idx`=0.

## Timing
- **Reset.** At the first edge with `rst`=1:
  - state=FILL, `idx`=0, `need_extra`=0.
  - `block`=0, `block_valid`=0, `last_block`=0.
  - `in_ready`=1 from the cycle after reset deasserts.
- **Reset mid-operation.** Reset in EMIT or mid-FILL discards the partial or held block; the next cycle shows `block_valid`=0.
- **Throughput.** One word per cycle in FILL.
- **Fill latency.** The word accepted at edge N that completes a block makes `block_valid`=1 from cycle N+1.
- **Minimum EMIT time.** EMIT lasts ≥1 cycle; a full block costs ≥18 cycles.
- **Stability.** `block` and `last_block` are constant while `block_valid`=1 and no transfer has occurred.
- **Back to FILL.** `in_ready` returns to 1 in the cycle after the final transfer.
- **Outputs.** All outputs are registered except `in_ready`, which decodes state combinationally.
- **Ignored inputs.** `in_valid` during EMIT is ignored, and so is `xor_ready` during FILL.

## Structure
- **`keccak_pkg`:**
  - `WIDTH`, `RATE_LANES`.
  - `state_t` enum {FILL, EMIT}.
  - `PAD_DOMAIN`=8'h06, `PAD_FINAL`=8'h80.
  - Lane-array typedef `state_arr_t` = [0:4][0:4][WIDTH-1:0], shared with `keccak_xor`.
  - Function `lane_xy(L)` returning x=L%5, y=L/5.
- **Sub-modules.** None required. Byte masking and pad-byte insertion are package functions (`byte_mask(n)`, `pad_byte_at(n)`).

## Test plan
- **Empty message.** `in_last`=1, `in_bytes`=0 → one block: lane0=0x0000000000000006, lane16=0x8000000000000000, rest 0, `last_block`=1. Through `keccak_xor`, hash = a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
- **"abc".** `in_data`=0x636261, `in_bytes`=3, last → lane0=0x0000000006636261, lane16=0x8000000000000000, `last_block`=1. Hash = 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- **200 bytes of 0xA3** (24 full words + `in_bytes`=8 last word):
  - Block 1: lanes 0..16 = 0xA3A3A3A3A3A3A3A3, `last_block`=0.
  - Block 2: lanes 0..7 = 0xA3..A3, lane8=0x0000000000000006, lane16=0x8000000000000000, `last_block`=1.
  - Hash = 79f38adec5c20307a98ef76e8324afbfd46cfd81b22e3973c65fa1bd9de31787.
- **135 bytes of 0xA3** (last word `in_bytes`=7 at `idx`=16) → single block, lane16=0x86A3A3A3A3A3A3A3, `last_block`=1.
- **136 bytes of 0xA3** (last word `in_bytes`=8 at `idx`=16):
  - First: full block with `last_block`=0.
  - After the transfer: a pad-only block, lane0=0x06, lane16=0x8000000000000000, `last_block`=1.
- **Backpressure and reset.**
  - Hold `xor_ready`=0 for 5 cycles in EMIT → `block` unchanged, `in_ready`=0 throughout.
  - Then assert `rst` for 1 cycle → `block_valid`=0 and `block`=0 next cycle, `in_ready`=1 after release.
